pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles that decode/execute flush is held after a redirect (legal range 1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the stall performance counter.
REQ-003 SHALL have port clock, input, 1, rising-edge clock; the clock is named clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset; the reset is named reset.
REQ-005 SHALL have ports rs1_decode and rs2_decode, input, 5 each, source registers of the instruction in decode.
REQ-006 SHALL have ports rd_execute (input, 5), memRead_execute (input, 1) and regWrite_execute (input, 1), the destination and load flags of the instruction in execute.
REQ-007 SHALL have port next_PC_select_execute, input, 2, redirect code: 00 sequential, 01 branch taken, 10 JAL, 11 JALR.
REQ-008 SHALL have ports mem_access_memory (input, 1, load/store in memory stage) and dmem_ready (input, 1, data memory done).
REQ-009 SHALL have port imem_ready, input, 1, instruction fetch data valid.
REQ-010 SHALL have output ports stall_fetch, stall_decode and stall_execute, 1 each, hold the respective pipe register.
REQ-011 SHALL have output ports flush_decode and flush_execute, 1 each, load a NOP (32'h00000013) bubble into the respective pipe register.
REQ-012 SHALL have output ports state (2, current FSM state), stall_count (CNT_WIDTH, cycles with stall_fetch=1), and input stall_count_clear (1).

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1, REDIRECT=2 and FETCH_WAIT=3; outputs are Mealy functions of state and inputs.
REQ-014 SHALL define load_use as memRead_execute & regWrite_execute & rd_execute!=0 & (rd_execute==rs1_decode | rd_execute==rs2_decode).
REQ-015 SHALL define redirect as next_PC_select_execute!=00 and dmem_wait as mem_access_memory & ~dmem_ready.
REQ-016 SHALL use event priority dmem_wait > redirect > load_use > ~imem_ready in every state that evaluates them.
REQ-017 RUN with dmem_wait SHALL assert all three stalls, save return state RUN, and go to MEM_WAIT.
REQ-018 RUN with redirect SHALL assert flush_decode and flush_execute and load flush_cnt=FLUSH_CYCLES-1; it SHALL go to REDIRECT if flush_cnt>0, else stay in RUN.
REQ-019 RUN with load_use SHALL assert stall_fetch, stall_decode and flush_execute for exactly one cycle and stay in RUN.
REQ-020 RUN with ~imem_ready SHALL assert stall_fetch and flush_decode and go to FETCH_WAIT.
REQ-021 MEM_WAIT SHALL assert all stalls while dmem_ready=0; in the dmem_ready=1 cycle it SHALL deassert all stalls and return to the saved state.
REQ-022 REDIRECT SHALL assert flush_decode and flush_execute, decrement flush_cnt each cycle, and go to RUN on the cycle flush_cnt==0.
REQ-023 REDIRECT with dmem_wait SHALL stall all stages, hold flush_cnt, save return state REDIRECT and go to MEM_WAIT.
REQ-024 REDIRECT with a new redirect SHALL reload flush_cnt=FLUSH_CYCLES-1.
REQ-025 FETCH_WAIT SHALL assert stall_fetch and flush_decode until imem_ready=1, then go to RUN; dmem_wait and redirect SHALL preempt it per REQ-016, with RUN as the saved state.
REQ-026 stall_count SHALL increment by 1 each cycle stall_fetch=1 and saturate at all-ones.
REQ-027 stall_count_clear SHALL zero stall_count; if clear and increment coincide, clear SHALL win.
REQ-028 A flush SHALL never be asserted on a stage whose stall is asserted in the same cycle, except the load_use pair defined in REQ-019.

Reset
REQ-029 While reset=1 all stall and flush outputs SHALL be 0 regardless of inputs.
REQ-030 On a reset edge the unit SHALL set state=RUN, flush_cnt=0, saved state=RUN and stall_count=0, including mid-REDIRECT or mid-MEM_WAIT.

Structure
REQ-031 The shared package SHALL hold the state encodings, redirect codes (PC_SEQ/PC_BR/PC_JAL/PC_JALR) and the NOP constant.
REQ-032 The load_use comparator SHALL be a combinational sub-module named pipeline_hazard_detect.
REQ-033 The implementation SHALL contain no other sub-modules.

Verification
REQ-034 Load x5 in execute with rs1_decode=5 -> one cycle with stall_fetch=stall_decode=flush_execute=1, then all 0; rd_execute=0 -> no stall.
REQ-035 JAL in RUN with FLUSH_CYCLES=2 -> flush_decode=flush_execute=1 for 2 cycles, state 0->2->0.
REQ-036 mem_access_memory=1 with dmem_ready low 3 cycles -> all stalls high 3 cycles, stall_count +3, deasserted in the ready cycle.
REQ-037 dmem_wait in the first REDIRECT cycle -> MEM_WAIT; after ready, return to REDIRECT with 1 flush cycle left.
REQ-038 Simultaneous redirect and load_use -> only the flush pair asserts, with no stall.
REQ-039 Reset asserted in MEM_WAIT -> outputs 0 while reset is high, state=0, stall_count=0; stall_count at all-ones stays saturated.

Source files
------------

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit:
// FSM state encodings, PC redirect codes and the bubble instruction.
package pipeline_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_REDIRECT   = 2'd2,
        ST_FETCH_WAIT = 2'd3
    } pcu_state_t;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JAL  = 2'b10;
    localparam logic [1:0] PC_JALR = 2'b11;

    // addi x0, x0, 0 -- loaded into a pipe register on flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Load-use hazard comparator between decode and execute.
// Ports: rs1_decode/rs2_decode (decode sources), rd_execute,
//        memRead_execute, regWrite_execute (execute load), load_use (out).
module pipeline_hazard_detect (
    input  logic [4:0] rs1_decode,
    input  logic [4:0] rs2_decode,
    input  logic [4:0] rd_execute,
    input  logic       memRead_execute,
    input  logic       regWrite_execute,
    output logic       load_use
);

    logic rd_nonzero;
    logic src_match;

    assign rd_nonzero = rd_execute != 5'd0;
    assign src_match  = (rd_execute == rs1_decode) |
                        (rd_execute == rs2_decode);

    assign load_use = memRead_execute & regWrite_execute &
                      rd_nonzero & src_match;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline stall/flush controller with a stall performance counter.
// Ports: clock, reset (sync, active-high); hazard inputs from decode,
//        execute, memory and fetch; stall_*/flush_* controls; state,
//        stall_count and stall_count_clear.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           rs1_decode,
    input  logic [4:0]           rs2_decode,
    input  logic [4:0]           rd_execute,
    input  logic                 memRead_execute,
    input  logic                 regWrite_execute,
    input  logic [1:0]           next_PC_select_execute,
    input  logic                 mem_access_memory,
    input  logic                 dmem_ready,
    input  logic                 imem_ready,
    input  logic                 stall_count_clear,
    output logic                 stall_fetch,
    output logic                 stall_decode,
    output logic                 stall_execute,
    output logic                 flush_decode,
    output logic                 flush_execute,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count
);

    // The redirect cycle itself flushes once, so REDIRECT covers
    // the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    pcu_state_t state_q, state_d;
    pcu_state_t ret_q, ret_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic redirect;
    logic dmem_wait;

    logic sf, sd, se, fd, fe;

    logic [CNT_WIDTH-1:0] cnt_q;

    pipeline_hazard_detect u_hazard (
        .rs1_decode       (rs1_decode),
        .rs2_decode       (rs2_decode),
        .rd_execute       (rd_execute),
        .memRead_execute  (memRead_execute),
        .regWrite_execute (regWrite_execute),
        .load_use         (load_use)
    );

    assign redirect  = next_PC_select_execute != PC_SEQ;
    assign dmem_wait = mem_access_memory & ~dmem_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_wait) begin
                    ret_d   = ST_RUN;
                    state_d = ST_MEM_WAIT;
                end else if (redirect) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD != 4'd0) ? ST_REDIRECT : ST_RUN;
                end else if (!load_use && !imem_ready) begin
                    state_d = ST_FETCH_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) state_d = ret_q;
            end
            ST_REDIRECT: begin
                if (dmem_wait) begin
                    ret_d   = ST_REDIRECT;
                    state_d = ST_MEM_WAIT;
                end else if (redirect) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD != 4'd0) ? ST_REDIRECT : ST_RUN;
                end else if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            ST_FETCH_WAIT: begin
                if (dmem_wait) begin
                    ret_d   = ST_RUN;
                    state_d = ST_MEM_WAIT;
                end else if (redirect) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD != 4'd0) ? ST_REDIRECT : ST_RUN;
                end else if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Mealy outputs; a stalled stage is never flushed in the same
    // cycle, except the load-use bubble into execute.
    always_comb begin
        sf = 1'b0;
        sd = 1'b0;
        se = 1'b0;
        fd = 1'b0;
        fe = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_wait) begin
                    {sf, sd, se} = 3'b111;
                end else if (redirect) begin
                    {fd, fe} = 2'b11;
                end else if (load_use) begin
                    {sf, sd, fe} = 3'b111;
                end else if (!imem_ready) begin
                    {sf, fd} = 2'b11;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready) {sf, sd, se} = 3'b111;
            end
            ST_REDIRECT: begin
                if (dmem_wait) {sf, sd, se} = 3'b111;
                else           {fd, fe}     = 2'b11;
            end
            ST_FETCH_WAIT: begin
                if (dmem_wait) begin
                    {sf, sd, se} = 3'b111;
                end else if (redirect) begin
                    {fd, fe} = 2'b11;
                end else if (!imem_ready) begin
                    {sf, fd} = 2'b11;
                end
            end
            default: ;
        endcase
        if (reset) begin
            sf = 1'b0;
            sd = 1'b0;
            se = 1'b0;
            fd = 1'b0;
            fe = 1'b0;
        end
    end

    assign stall_fetch   = sf;
    assign stall_decode  = sd;
    assign stall_execute = se;
    assign flush_decode  = fd;
    assign flush_execute = fe;
    assign state         = state_q;

    // Saturating stall counter; clear beats increment
    always_ff @(posedge clock) begin
        if (reset || stall_count_clear) begin
            cnt_q <= '0;
        end else if (sf && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit (FLUSH_CYCLES=2, CNT_WIDTH=4).
// Driver queues hand-computed expectations; a negedge monitor checks them.
module tb_pipeline_control_unit;

    logic       clock;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       mr, rw, ma, dr, ir, clr;
    logic [1:0] npc;
    logic       stall_fetch, stall_decode, stall_execute;
    logic       flush_decode, flush_execute;
    logic [1:0] state;
    logic [3:0] stall_count;

    typedef struct {
        logic [4:0] o;
        logic [1:0] st;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    pipeline_control_unit #(
        .FLUSH_CYCLES (2),
        .CNT_WIDTH    (4)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .rs1_decode             (rs1),
        .rs2_decode             (rs2),
        .rd_execute             (rd),
        .memRead_execute        (mr),
        .regWrite_execute       (rw),
        .next_PC_select_execute (npc),
        .mem_access_memory      (ma),
        .dmem_ready             (dr),
        .imem_ready             (ir),
        .stall_count_clear      (clr),
        .stall_fetch            (stall_fetch),
        .stall_decode           (stall_decode),
        .stall_execute          (stall_execute),
        .flush_decode           (flush_decode),
        .flush_execute          (flush_execute),
        .state                  (state),
        .stall_count            (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one expected entry per driven cycle
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            logic [4:0] got;
            e   = sb.pop_front();
            got = {stall_fetch, stall_decode, stall_execute,
                   flush_decode, flush_execute};
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL %s ctl got=%b want=%b", e.tag, got, e.o);
            end
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state got=%0d want=%0d",
                         e.tag, state, e.st);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s count got=%0d want=%0d",
                         e.tag, stall_count, e.cnt);
            end
        end
    end

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        mr = 1'b0; rw = 1'b1; npc = 2'b00;
        ma = 1'b0; dr = 1'b1; ir = 1'b1;
        clr = 1'b0; reset = 1'b0;
    endtask

    // o = {stall_fetch, stall_decode, stall_execute, flush_d, flush_e}
    task automatic go(input logic [4:0] o, input logic [1:0] st,
                      input logic [3:0] c, input string tag);
        exp_t x;
        x.o = o; x.st = st; x.cnt = c; x.tag = tag;
        sb.push_back(x);
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        int n;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        idle();

        // reset gates outputs even with hazards present
        reset = 1'b1; ma = 1'b1; dr = 1'b0; npc = 2'b10;
        go(5'b00000, 2'd0, 4'd0, "rst_out");
        go(5'b00000, 2'd0, 4'd0, "idle");

        // load-use
        rd = 5'd5; mr = 1'b1; rs1 = 5'd5;
        go(5'b11001, 2'd0, 4'd0, "lu_rs1");
        go(5'b00000, 2'd0, 4'd1, "lu_after");
        rd = 5'd0; rs1 = 5'd0; mr = 1'b1;
        go(5'b00000, 2'd0, 4'd1, "lu_x0");
        rd = 5'd7; rs2 = 5'd7; mr = 1'b1;
        go(5'b11001, 2'd0, 4'd1, "lu_rs2");
        rd = 5'd7; rs2 = 5'd7;
        go(5'b00000, 2'd0, 4'd2, "no_load");

        // JAL redirect: two flush cycles
        npc = 2'b10;
        go(5'b00011, 2'd0, 4'd2, "jal_run");
        go(5'b00011, 2'd2, 4'd2, "jal_redir");
        go(5'b00000, 2'd0, 4'd2, "jal_done");

        // redirect beats load-use
        npc = 2'b01; rd = 5'd5; mr = 1'b1; rs1 = 5'd5;
        go(5'b00011, 2'd0, 4'd2, "br_lu");
        go(5'b00011, 2'd2, 4'd2, "br_redir");

        // data memory wait, three cycles low
        ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd0, 4'd2, "mw0");
        ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd1, 4'd3, "mw1");
        ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd1, 4'd4, "mw2");
        ma = 1'b1; dr = 1'b1;
        go(5'b00000, 2'd1, 4'd5, "mw_ready");
        go(5'b00000, 2'd0, 4'd5, "mw_done");

        // dmem wait inside REDIRECT, then resume REDIRECT
        npc = 2'b11;
        go(5'b00011, 2'd0, 4'd5, "jalr");
        ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd2, 4'd5, "redir_mw");
        ma = 1'b1; dr = 1'b1;
        go(5'b00000, 2'd1, 4'd6, "redir_ready");
        go(5'b00011, 2'd2, 4'd6, "redir_resume");
        go(5'b00000, 2'd0, 4'd6, "redir_done");

        // fetch wait
        ir = 1'b0;
        go(5'b10010, 2'd0, 4'd6, "fw0");
        ir = 1'b0;
        go(5'b10010, 2'd3, 4'd7, "fw1");
        go(5'b00000, 2'd3, 4'd8, "fw_ready");
        ir = 1'b0;
        go(5'b10010, 2'd0, 4'd8, "fw2");
        ir = 1'b0; npc = 2'b01;
        go(5'b00011, 2'd3, 4'd9, "fw_redir");
        go(5'b00011, 2'd2, 4'd9, "fw_redir2");

        // redirect reload inside REDIRECT
        npc = 2'b01;
        go(5'b00011, 2'd0, 4'd9, "rl0");
        npc = 2'b10;
        go(5'b00011, 2'd2, 4'd9, "rl_reload");
        go(5'b00011, 2'd2, 4'd9, "rl_last");
        go(5'b00000, 2'd0, 4'd9, "rl_done");

        // dmem wait preempts fetch wait
        ir = 1'b0;
        go(5'b10010, 2'd0, 4'd9, "fwm0");
        ir = 1'b0; ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd3, 4'd10, "fwm_mw");
        ma = 1'b1; dr = 1'b1; ir = 1'b1;
        go(5'b00000, 2'd1, 4'd11, "fwm_ready");
        go(5'b00000, 2'd0, 4'd11, "fwm_done");

        // clear wins over increment
        clr = 1'b1; ir = 1'b0;
        go(5'b10010, 2'd0, 4'd11, "clr_inc");
        go(5'b00000, 2'd3, 4'd0, "clr_after");

        // saturate the counter in MEM_WAIT
        ma = 1'b1; dr = 1'b0;
        go(5'b11100, 2'd0, 4'd0, "sat0");
        for (int k = 1; k <= 17; k++) begin
            ma = 1'b1; dr = 1'b0;
            go(5'b11100, 2'd1, (k > 15) ? 4'd15 : 4'(k), "sat");
        end

        // reset in MEM_WAIT
        reset = 1'b1; ma = 1'b1; dr = 1'b0;
        go(5'b00000, 2'd1, 4'd15, "rst_mw");
        reset = 1'b1; ma = 1'b1; dr = 1'b0; npc = 2'b11;
        go(5'b00000, 2'd0, 4'd0, "rst_hold");
        go(5'b00000, 2'd0, 4'd0, "post_rst");

        // reset in REDIRECT
        npc = 2'b10;
        go(5'b00011, 2'd0, 4'd0, "pre_rst_rd");
        reset = 1'b1; npc = 2'b10;
        go(5'b00000, 2'd2, 4'd0, "rst_redir");
        go(5'b00000, 2'd0, 4'd0, "rst_redir_done");
        npc = 2'b10;
        go(5'b00011, 2'd0, 4'd0, "jal_again");
        go(5'b00011, 2'd2, 4'd0, "jal_again2");
        go(5'b00000, 2'd0, 4'd0, "jal_again3");

        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
